uart_tx_serializer: RTL

Byte-level UART transmitter that sits directly downstream of the sample-to-byte sequencer in the MEMS readout path. It accepts one 8-bit byte per `rdy` rising edge while `ready` is high and serialises it LSB-first onto the `tx` line as an 8N1 frame, or 8E1 when parity is configured in. It drops `ready` for the whole frame so the sequencer paces its three bytes per 24-bit sample.

---
 rtl/uart_tx_serializer_pkg.sv | 20 ++
 rtl/uart_tx_serializer_if.sv | 13 +
 rtl/uart_tx_serializer_baud_tick.sv | 19 +
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and helpers for the UART transmit path (uart_pkg).
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Truncating division; callers must guarantee a result of at least 2.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line between the sample-to-byte sequencer and the UART transmitter.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] UART_data;
  logic                   rdy;
  logic                   ready;
  logic                   tx;
  logic                   ovr;

  modport master (output UART_data, output rdy, input ready, input tx, input ovr);
  modport slave  (input UART_data, input rdy, output ready, output tx, output ovr);
endinterface

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period counter: one-cycle tick at CLKS_PER_BIT-1, held at zero while clear is high.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  logic [15:0] cnt;

  assign tick = ~clear & (cnt == 16'(CLKS_PER_BIT - 1));

  // Wrapping on tick makes every state change see a fresh count of zero.
  always_ff @(posedge CLK) begin
    if (!reset || clear || tick) cnt <= '0;
    else                         cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// LSB-first 8N1 UART transmitter; define UART_PARITY_EN for 8E1 (even parity bit after data).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                CLK,
  input  logic                reset,
  uart_tx_serializer_if.slave bus
);
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t         state;
  logic [UART_DATA_W-1:0] shreg;
  logic [2:0]             bitcnt;
  logic                   rdy_q;
  logic                   tx_r;
  logic                   ready_r;
  logic                   ovr_r;
  logic                   tick;
  logic                   rise;
  logic                   accept;
`ifdef UART_PARITY_EN
  logic                   parity;
`endif

  assign rise   = bus.rdy & ~rdy_q;
  assign accept = rise & ready_r;

  assign bus.tx    = tx_r;
  assign bus.ready = ready_r;
  assign bus.ovr   = ovr_r;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  // tx is registered one state ahead so the line changes on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      rdy_q   <= bus.rdy;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      ovr_r   <= 1'b0;
`ifdef UART_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      rdy_q <= bus.rdy;
      if (rise && !ready_r) ovr_r <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= bus.UART_data;
`ifdef UART_PARITY_EN
            parity  <= ^bus.UART_data;
`endif
            bitcnt  <= '0;
            tx_r    <= 1'b0;
            ready_r <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_r  <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'(UART_DATA_W - 1)) begin
              bitcnt <= '0;
`ifdef UART_PARITY_EN
              tx_r   <= parity;
              state  <= PARITY;
`else
              tx_r   <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              tx_r <= shreg[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_r  <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bitcnt == 3'(STOP_BITS - 1)) begin
              bitcnt  <= '0;
              ready_r <= 1'b1;
              tx_r    <= 1'b1;
              state   <= IDLE;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule
